// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: NRD combinational read ports, one write-through writeback
// port, and a per-register pending counter scoreboard for long-latency destinations.
module regfile_scoreboard #(
    parameter int DW      = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int PEND_W  = 2,
    parameter bit ZERO_R0 = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_use,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              wr_pend_clr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_ok,
    input  logic              stall_i,
    input  logic              flush,
    output logic              busy_any
);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1'b1);

    logic [DW-1:0]     regs_r    [NREG];
    logic [PEND_W-1:0] cnt_r     [NREG];
    logic [PEND_W-1:0] cnt_nxt_s [NREG];
    logic              busy_any_r;
    logic              busy_nxt_s;
    logic              wr_act_s;
    logic              iss_ok_s;
    logic              inc_s;
    logic              dec_s;

    function automatic logic is_r0(input logic [AW-1:0] a);
        return (ZERO_R0 == 1'b1) && (a == {AW{1'b0}});
    endfunction

    assign wr_act_s = wr_en && !stall_i && !is_r0(wr_addr);
    assign iss_ok   = iss_ok_s;
    assign busy_any = busy_any_r;

    // Issue acceptance and scoreboard increment/decrement requests
    always_comb begin
        iss_ok_s = (cnt_r[iss_addr] != PEND_MAX) &&
                   ((cnt_r[iss_addr] == PEND_ZERO) || (PEND_W > 1));
        inc_s    = iss_en && iss_ok_s && !is_r0(iss_addr);
        dec_s    = wr_en && wr_pend_clr;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra_s;
        logic          byp_s;
        logic [DW-1:0] data_s;
        logic          busy_s;

        assign ra_s = rd_addr[k*AW +: AW];

        // Read mux with write-through bypass; a retiring last op hides the hazard
        always_comb begin
            byp_s = wr_act_s && (wr_addr == ra_s);
            if (byp_s) begin
                data_s = wr_data;
            end else begin
                data_s = regs_r[ra_s];
            end
            if (is_r0(ra_s)) begin
                busy_s = 1'b0;
            end else if (byp_s && wr_pend_clr && (cnt_r[ra_s] == PEND_ONE)) begin
                busy_s = 1'b0;
            end else begin
                busy_s = rd_use[k] && (cnt_r[ra_s] != PEND_ZERO);
            end
        end

        assign rd_data[k*DW +: DW] = data_s;
        assign rd_busy[k]          = busy_s;
    end

    // Next pending count per register: flush, then stall, then issue/retire
    always_comb begin
        busy_nxt_s = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt_s[r] = cnt_r[r];
            if (flush) begin
                cnt_nxt_s[r] = PEND_ZERO;
            end else if (stall_i) begin
                cnt_nxt_s[r] = cnt_r[r];
            end else if (inc_s && dec_s && (iss_addr == AW'(r)) && (wr_addr == AW'(r))) begin
                cnt_nxt_s[r] = cnt_r[r];
            end else if (inc_s && (iss_addr == AW'(r))) begin
                cnt_nxt_s[r] = cnt_r[r] + PEND_ONE;
            end else if (dec_s && (wr_addr == AW'(r)) && (cnt_r[r] != PEND_ZERO)) begin
                cnt_nxt_s[r] = cnt_r[r] - PEND_ONE;
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
            busy_nxt_s = busy_nxt_s | (cnt_nxt_s[r] != PEND_ZERO);
        end
    end

    // Scoreboard counters and the registered any-pending flag
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= PEND_ZERO;
            end
            busy_any_r <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            busy_any_r <= busy_nxt_s;
        end
    end

    // Register array writeback
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= {DW{1'b0}};
            end
        end else if (wr_act_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end
endmodule
